// File: rtl/cfg_sel_loader_pkg.sv
// rtl/cfg_sel_loader_pkg.sv - shared defaults and state encoding for the select-configuration loader
// Package cfg_defs: default mux geometry (shared with the fabric mux instantiation)
// and the loader FSM state encoding.
package cfg_defs;

    // Defaults shared with the fabric top-level mux instantiation.
    localparam int SEL_DEF     = 4;
    localparam int NUM_MUX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/cfg_sel_loader_if.sv
// rtl/cfg_sel_loader_if.sv - serial configuration stream handshake bundle
// Signals:
//   cfg_valid : cfg_bit is valid this cycle            (master -> slave)
//   cfg_bit   : serial config bit, MSB of frame first  (master -> slave)
//   cfg_last  : marks the final bit of the frame       (master -> slave)
//   cfg_ready : slave accepts a bit this cycle         (slave -> master)
interface cfg_sel_loader_if;
    logic cfg_valid;
    logic cfg_bit;
    logic cfg_last;
    logic cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_bit,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_bit,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/cfg_shift_reg.sv
// rtl/cfg_shift_reg.sv - W-bit shadow shift register, MSB-first serial load
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over shift_en)
//   shift_en   : shift din into bit 0, moving existing bits toward the MSB
//   din        : serial input bit
//   q          : register contents
module cfg_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/cfg_sel_loader.sv
// rtl/cfg_sel_loader.sv - serial-to-parallel mux select loader with atomic commit
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_start : pulse that opens (or restarts) a frame
//   cfg        : serial config stream (slave side of cfg_sel_loader_if)
//   sel_bus    : committed selects, mux k uses sel_bus[k*SEL +: SEL]
//   cfg_done   : one-cycle pulse on a successful commit
//   cfg_err    : sticky framing error, cleared by load_start
//   busy       : high while shifting or committing
module cfg_sel_loader
    import cfg_defs::*;
#(
    parameter  int SEL     = SEL_DEF,
    parameter  int NUM_MUX = NUM_MUX_DEF,
    localparam int CFG_W   = SEL * NUM_MUX,
    localparam int CNT_W   = $clog2(CFG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    cfg_sel_loader_if.slave  cfg,
    output logic [CFG_W-1:0] sel_bus,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             busy
);

    cfg_state_e       state;
    cfg_state_e       next_state;
    logic [CNT_W-1:0] count;
    logic [CFG_W-1:0] shadow;

    logic ready_c;
    logic busy_c;
    logic shift_en;
    logic clr_frame;
    logic cnt_inc;
    logic err_set;
    logic commit;
    logic at_last_bit;

    assign at_last_bit = (count == CNT_W'(CFG_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        shift_en   = 1'b0;
        clr_frame  = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    next_state = SHIFT;
                    clr_frame  = 1'b1;
                end
            end
            SHIFT: begin
                ready_c = 1'b1;
                busy_c  = 1'b1;
                // A restart drops any beat presented in the same cycle.
                if (load_start) begin
                    clr_frame = 1'b1;
                end else if (cfg.cfg_valid) begin
                    shift_en = 1'b1;
                    if (at_last_bit) begin
                        if (cfg.cfg_last) begin
                            next_state = COMMIT;
                        end else begin
                            next_state = IDLE;
                            err_set    = 1'b1;
                        end
                    end else if (cfg.cfg_last) begin
                        next_state = IDLE;
                        err_set    = 1'b1;
                    end else begin
                        // Only incremented while staying in SHIFT, so never wraps.
                        cnt_inc = 1'b1;
                    end
                end
            end
            COMMIT: begin
                busy_c     = 1'b1;
                commit     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign cfg.cfg_ready = ready_c;
    assign busy          = busy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr_frame) begin
            count <= '0;
        end else if (cnt_inc) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else if (clr_frame) begin
            cfg_err <= 1'b0;
        end else if (err_set) begin
            cfg_err <= 1'b1;
        end
    end

    // Commit register: all slices update on the same edge, and only here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_bus  <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= commit;
            if (commit) begin
                sel_bus <= shadow;
            end
        end
    end

    cfg_shift_reg #(
        .W (CFG_W)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_frame),
        .shift_en (shift_en),
        .din      (cfg.cfg_bit),
        .q        (shadow)
    );

endmodule

// File: tb/tb_cfg_sel_loader.sv
// tb/tb_cfg_sel_loader.sv - randomized self-checking bench for cfg_sel_loader
module tb_cfg_sel_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] sel_bus;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_sel = 16'h0;

    cfg_sel_loader_if cif ();

    always #5 clk = ~clk;

    cfg_sel_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .cfg        (cif),
        .sel_bus    (sel_bus),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive nbits of val MSB-first; cfg_last on beat number last_at (1-based, 0 = never).
    // gap_pct >= 100 inserts exactly one idle cycle before each beat.
    task automatic send_bits(input logic [15:0] val, input int nbits, input int last_at,
                             input int gap_pct);
        for (int i = 0; i < nbits; i++) begin
            int gaps;
            if (gap_pct >= 100) gaps = 1;
            else gaps = ($urandom_range(99) < gap_pct) ? $urandom_range(3, 1) : 0;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                load_start    = 1'b0;
                cif.cfg_valid = 1'b0;
                cif.cfg_last  = 1'b0;
                check("ready_gap", 32'(cif.cfg_ready), 32'd1);
                check("busy_gap", 32'(busy), 32'd1);
            end
            @(negedge clk);
            load_start = 1'b0;
            check("ready_beat", 32'(cif.cfg_ready), 32'd1);
            cif.cfg_valid = 1'b1;
            cif.cfg_bit   = val[15-i];
            cif.cfg_last  = (i + 1 == last_at);
        end
    endtask

    // Called with the frame's final beat on the bus; checks the frame outcome.
    task automatic finish_frame(input logic [15:0] val, input bit ok);
        @(negedge clk);
        cif.cfg_valid = 1'b0;
        cif.cfg_last  = 1'b0;
        if (ok) begin
            check("commit_done_early", 32'(cfg_done), 32'd0);
            check("commit_busy", 32'(busy), 32'd1);
            check("commit_ready", 32'(cif.cfg_ready), 32'd0);
            check("commit_sel_hold", 32'(sel_bus), 32'(exp_sel));
            @(negedge clk);
            exp_sel = val;
            check("done_pulse", 32'(cfg_done), 32'd1);
            check("sel_commit", 32'(sel_bus), 32'(exp_sel));
            check("busy_after", 32'(busy), 32'd0);
            check("err_ok", 32'(cfg_err), 32'd0);
            @(negedge clk);
            check("done_width", 32'(cfg_done), 32'd0);
        end else begin
            check("err_set", 32'(cfg_err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_no_done", 32'(cfg_done), 32'd0);
            check("err_sel_hold", 32'(sel_bus), 32'(exp_sel));
            @(negedge clk);
            check("err_no_done2", 32'(cfg_done), 32'd0);
            check("err_sticky", 32'(cfg_err), 32'd1);
        end
    endtask

    task automatic open_frame();
        @(negedge clk);
        load_start    = 1'b1;
        cif.cfg_valid = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        check("start_err_clr", 32'(cfg_err), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    // Frame rule: exactly 16 bits with cfg_last on the 16th commits;
    // last earlier ends the frame in error there; 16 bits without last is an error.
    task automatic run_frame(input logic [15:0] val, input int last_at, input int gap_pct);
        int n;
        n = (last_at >= 1 && last_at < 16) ? last_at : 16;
        open_frame();
        send_bits(val, n, last_at, gap_pct);
        finish_frame(val, last_at == 16);
    endtask

    initial begin
        cif.cfg_valid = 1'b0;
        cif.cfg_bit   = 1'b0;
        cif.cfg_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel_bus), 32'd0);
        check("rst_ready", 32'(cif.cfg_ready), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Continuous and gapped frames.
        run_frame(16'hA5C3, 16, 0);
        check("mux0_sel", 32'(sel_bus[3:0]), 32'h3);
        check("mux3_sel", 32'(sel_bus[15:12]), 32'hA);
        run_frame(16'hA5C3, 16, 100);

        // Early last and missing last leave the committed value alone.
        run_frame(16'h1234, 16, 0);
        run_frame(16'h5A5A, 10, 0);
        run_frame(16'h1234, 16, 0);
        run_frame(16'hCCCC, 0, 0);

        // Restart mid-frame with a beat in the restart cycle.
        open_frame();
        send_bits(16'h0000, 7, 0, 0);
        @(negedge clk);
        load_start    = 1'b1;
        cif.cfg_valid = 1'b1;
        cif.cfg_bit   = 1'b0;
        cif.cfg_last  = 1'b0;
        send_bits(16'hFFFF, 16, 16, 0);
        finish_frame(16'hFFFF, 1'b1);

        // Reset in the middle of a frame.
        run_frame(16'hBEEF, 16, 0);
        open_frame();
        send_bits(16'h0F0F, 8, 0, 0);
        @(negedge clk);
        cif.cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_sel = 16'h0;
        check("midrst_sel", 32'(sel_bus), 32'd0);
        check("midrst_ready", 32'(cif.cfg_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(16'h0F0F, 16, 0);

        // Randomized frames, with junk beats in IDLE now and then.
        repeat (24) begin
            logic [15:0] v;
            int          k;
            int          la;
            v  = 16'($urandom);
            k  = $urandom_range(3);
            la = (k <= 1) ? 16 : (k == 2) ? $urandom_range(15, 1) : 0;
            run_frame(v, la, $urandom_range(50));
            if ($urandom_range(5) == 0) begin
                @(negedge clk);
                cif.cfg_valid = 1'b1;
                cif.cfg_bit   = 1'($urandom);
                cif.cfg_last  = 1'($urandom);
                check("idle_ready", 32'(cif.cfg_ready), 32'd0);
                @(negedge clk);
                cif.cfg_valid = 1'b0;
                cif.cfg_last  = 1'b0;
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_sel", 32'(sel_bus), 32'(exp_sel));
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
